irq_service_sequencer: RTL

- Sequential requester-side counterpart to our 27-channel combinational interrupt priority controller: 3 banks (A > B > C) of 9 channels, with a shared 9-bit channel-enable mask.
- Captures request edges into sticky pending bits and resolves priority.
- Presents exactly one interrupt at a time to the host over a valid/ack handshake, holds it in service until end-of-interrupt (EOI), then clears the pending bit.
- Sits between the peripheral request lines and the CPU interrupt port.

---
 rtl/irq_service_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/irq_service_sequencer.sv
// Requester-side interrupt sequencer: captures request edges from three
// 9-channel banks, arbitrates A > B > C (lowest channel first) and presents one interrupt at a time.
module irq_service_sequencer (
    input  logic       CK,
    input  logic       RSTN,
    input  logic [8:0] req_a,
    input  logic [8:0] req_b,
    input  logic [8:0] req_c,
    input  logic [8:0] en,
    input  logic       ack,
    input  logic       eoi,
    output logic       irq,
    output logic       irq_pa,
    output logic       irq_pb,
    output logic       irq_pc,
    output logic [3:0] irq_code,
    output logic       insvc,
    output logic       pend_any
);

    localparam int unsigned NCH    = 9;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned NBANK  = 3;
    localparam logic [CODE_W-1:0] NONE_CODE = 4'hF;

    // one-hot bank encoding: bit 0 = A, bit 1 = B, bit 2 = C
    localparam logic [NBANK-1:0] BANK_A    = 3'b001;
    localparam logic [NBANK-1:0] BANK_B    = 3'b010;
    localparam logic [NBANK-1:0] BANK_C    = 3'b100;
    localparam logic [NBANK-1:0] BANK_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic [NCH-1:0]    prev_a, prev_b, prev_c;
    logic [NCH-1:0]    pend_a, pend_b, pend_c;
    logic [NCH-1:0]    pend_a_nxt, pend_b_nxt, pend_c_nxt;
    logic [NCH-1:0]    rise_a, rise_b, rise_c;
    logic [NCH-1:0]    act_a, act_b, act_c;
    logic [NCH-1:0]    clr_a, clr_b, clr_c;
    logic [NCH-1:0]    svc_mask;
    logic [NBANK-1:0]  bank_q, bank_nxt;
    logic [CODE_W-1:0] code_q, code_nxt;
    logic [NBANK-1:0]  win_bank;
    logic [CODE_W-1:0] win_code;
    logic              win_valid;
    logic              do_clr;

    // Lowest set index of a bank vector; NONE_CODE when empty.
    function automatic logic [CODE_W-1:0] first_idx(input logic [NCH-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = NONE_CODE;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (v[i]) idx = CODE_W'(i);
        end
        return idx;
    endfunction

    // Edge detection and enabled-pending vectors.
    always_comb begin
        rise_a = req_a & ~prev_a;
        rise_b = req_b & ~prev_b;
        rise_c = req_c & ~prev_c;
        act_a  = pend_a & en;
        act_b  = pend_b & en;
        act_c  = pend_c & en;
    end

    // Fixed-priority winner across banks.
    always_comb begin
        win_valid = 1'b1;
        win_bank  = BANK_NONE;
        win_code  = NONE_CODE;
        if (|act_a) begin
            win_bank = BANK_A;
            win_code = first_idx(act_a);
        end else if (|act_b) begin
            win_bank = BANK_B;
            win_code = first_idx(act_b);
        end else if (|act_c) begin
            win_bank = BANK_C;
            win_code = first_idx(act_c);
        end else begin
            win_valid = 1'b0;
        end
    end

    // Next-state, latched bank/code and EOI clear request.
    always_comb begin
        state_nxt = state_q;
        bank_nxt  = bank_q;
        code_nxt  = code_q;
        do_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_nxt = REQ;
                    bank_nxt  = win_bank;
                    code_nxt  = win_code;
                end
            end
            REQ: begin
                if (ack) state_nxt = SERV;
            end
            SERV: begin
                if (eoi) begin
                    state_nxt = IDLE;
                    bank_nxt  = BANK_NONE;
                    code_nxt  = NONE_CODE;
                    do_clr    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                bank_nxt  = BANK_NONE;
                code_nxt  = NONE_CODE;
            end
        endcase
    end

    // Clear of the in-service bit; a coincident new edge re-sets it.
    always_comb begin
        svc_mask   = NCH'(1) << code_q;
        clr_a      = (do_clr && bank_q[0]) ? svc_mask : '0;
        clr_b      = (do_clr && bank_q[1]) ? svc_mask : '0;
        clr_c      = (do_clr && bank_q[2]) ? svc_mask : '0;
        pend_a_nxt = (pend_a & ~clr_a) | rise_a;
        pend_b_nxt = (pend_b & ~clr_b) | rise_b;
        pend_c_nxt = (pend_c & ~clr_c) | rise_c;
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            prev_a   <= '0;
            prev_b   <= '0;
            prev_c   <= '0;
            pend_a   <= '0;
            pend_b   <= '0;
            pend_c   <= '0;
            bank_q   <= BANK_NONE;
            code_q   <= NONE_CODE;
            irq      <= 1'b0;
            insvc    <= 1'b0;
            pend_any <= 1'b0;
        end else begin
            prev_a   <= req_a;
            prev_b   <= req_b;
            prev_c   <= req_c;
            pend_a   <= pend_a_nxt;
            pend_b   <= pend_b_nxt;
            pend_c   <= pend_c_nxt;
            bank_q   <= bank_nxt;
            code_q   <= code_nxt;
            irq      <= (state_nxt == REQ);
            insvc    <= (state_nxt == SERV);
            pend_any <= |{pend_a_nxt, pend_b_nxt, pend_c_nxt};
        end
    end

    assign irq_pa   = bank_q[0];
    assign irq_pb   = bank_q[1];
    assign irq_pc   = bank_q[2];
    assign irq_code = code_q;

endmodule
